data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

- Data-side memory responder for the MIPS32 pipeline. It sits on the far end of the MEM-stage data bus and serves its byte-lane load/store requests (addr, we, sel, data, ce) from an on-chip synchronous-read RAM.
- Stores complete in one cycle.
- Loads take two cycles: the block raises a stall request to the pipeline controller for the first cycle and returns the read word in the second.
- Out-of-range accesses are flagged and never corrupt memory.

## Interface
Parameters:
- DEPTH_LOG2, 12: RAM holds 2^DEPTH_LOG2 32-bit words (16 KiB default).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mem_ce_i  in  1  request valid (`ChipEnable`)
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address; word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored (lane choice is via sel)
- mem_sel_i  in  4  byte enables, big-endian: sel[3] = bits 31:24 = byte offset 0, sel[0] = bits 7:0 = offset 3
- mem_data_i  in  32  store data, already lane-replicated by requester
- flush_i  in  1  pipeline flush; cancels a load not yet issued
- mem_data_o  out  32  load data, valid only in RESP state, else `ZeroWord`
- stallreq_o  out  1  combinational stall request to pipeline controller
- addr_err_o  out  1  one-cycle pulse on out-of-range access

## Operation
- Range check: an access is out of range (OOR) when addr[31:DEPTH_LOG2+2] is not zero.
- Store (ce=1, we=1, in range):
  - For each i, RAM byte lane i is written at the clock edge when sel[i]=1.
  - sel=0000 writes nothing and raises no error.
  - No stall.
- Store OOR: the write is dropped and addr_err_o pulses.
- Load (ce=1, we=0, in range, flush_i=0) in IDLE:
  - stallreq_o=1.
  - RAM read is issued at the word index.
  - Next state is RESP.
- Load OOR:
  - No RAM read and no stall.
  - mem_data_o=`ZeroWord`, addr_err_o pulses.
  - State stays IDLE.
- RESP:
  - mem_data_o = registered RAM read word (full 32 bits; lane extraction and sign extension are the requester's job).
  - stallreq_o=0.
  - Next state is IDLE unconditionally.
  - A store presented in RESP is still performed.
  - A load presented in RESP is not re-issued (it is the held request being answered).
- Back-to-back loads: each load costs IDLE→RESP→IDLE, i.e. one stall cycle per load.
- flush_i=1 in IDLE: the load is suppressed (no stall, no state change). Stores are unaffected, because the MEM stage already qualifies them.
- flush_i=1 in RESP: returns to IDLE as normal; the data is simply unused.
- Read-after-write to the same word in consecutive cycles returns the new data, because the store commits at the edge before the read edge.
- Same-cycle store and read never happen: a load and a store are never simultaneously presented.

## Timing
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - mem_data_o=0, stallreq_o=0, addr_err_o=0, read register=0.
  - RAM contents are not cleared.
- Reset asserted during RESP aborts the response; after release the block is in IDLE.
- Load latency: request seen in cycle N (stallreq_o=1); data valid in cycle N+1, consumed by the MEM stage at the N+1→N+2 edge.
- Store latency: committed at the end of the request cycle, and visible to a load issued in the next cycle.
- stallreq_o depends combinationally on ce/we/addr/flush_i/state. There is no path from mem_data_i to any output.
- addr_err_o is combinational, high in the request cycle only.

## Structure
- The shared defines file supplies `ChipEnable`, `WriteEnable`, `ZeroWord` and `RegBus`.
- New define `DataMemNumLog2` is the default for DEPTH_LOG2.
- State encoding (IDLE=1'b0, RESP=1'b1) is local to the block.
- One sub-module: `data_ram_bank`.
  - Four 8-bit-wide arrays, each with a per-lane write enable.
  - Registered read port (read data appears the cycle after the address).
  - No reset on the arrays.
- `data_ram_ctrl` contains the FSM, the range check and the output muxing.

## Test plan
- Reset: hold rst=0 mid-load → mem_data_o=0, stallreq_o=0, state IDLE; after release, a load of a previously stored word returns the stored value.
- Full-word store then load: SW 0xDEADBEEF @0x100, sel=1111; next cycle LW @0x100 → stallreq_o=1 for one cycle, then mem_data_o=0xDEADBEEF.
- Byte lanes:
  - Start from 0x00000000 @0x40.
  - SB data 0xAAAAAAAA sel=0100, then SH data 0x12341234 sel=0011.
  - Then load → 0x00AA1234.
- Back-to-back loads: @0x0 (holds 0x11111111) and @0x4 (holds 0x22222222) → stallreq pattern 1,0,1,0; data 0x11111111 then 0x22222222.
- OOR (DEPTH_LOG2=12): SW @0x00010000 → addr_err_o pulse and word 0 unchanged; LW @0x00010000 → no stall, data 0, addr_err_o pulse.
- Flush: LW with flush_i=1 in IDLE → stallreq_o=0, state stays IDLE; sel=0000 store → memory unchanged, no error.

Source files
------------

// File: rtl/data_ram_ctrl_pkg.sv
// Shared constants for the data-side RAM responder: bus widths, chip/write
// enable levels, default depth and the local FSM encoding.
package data_ram_ctrl_pkg;

  localparam int REG_BUS           = 32;
  localparam int NUM_LANES         = 4;
  localparam int DATA_MEM_NUM_LOG2 = 12;

  typedef logic [REG_BUS-1:0] reg_bus_t;

  localparam logic     CHIP_ENABLE  = 1'b1;
  localparam logic     WRITE_ENABLE = 1'b1;
  localparam reg_bus_t ZERO_WORD    = '0;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/data_ram_bank.sv
// Four byte-wide RAM lanes with per-lane write enables and one registered
// read port; lane i holds bits 8*i+7:8*i of each word.
module data_ram_bank
  import data_ram_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DATA_MEM_NUM_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_LANES-1:0]  we_lane_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  reg_bus_t              wdata_i,
  input  logic                  re_i,
  output reg_bus_t              rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  reg_bus_t rd_word;
  reg_bus_t rdata_d;
  reg_bus_t rdata_q;

  // Arrays carry no reset so they map onto plain RAM macros.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we_lane_i[i]) begin
        mem[addr_i] <= wdata_i[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = mem[addr_i];
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= ZERO_WORD;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// MEM-stage data responder: single-cycle stores, two-cycle loads with a
// one-cycle stall request, and out-of-range flagging that never writes RAM.
module data_ram_ctrl
  import data_ram_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = DATA_MEM_NUM_LOG2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mem_ce_i,
  input  logic           mem_we_i,
  input  logic [31:0]    mem_addr_i,
  input  logic [3:0]     mem_sel_i,
  input  logic [31:0]    mem_data_i,
  input  logic           flush_i,
  output logic [31:0]    mem_data_o,
  output logic           stallreq_o,
  output logic           addr_err_o,
  output logic [0:0]     dbg_state_o
);

  // Handshake: a request is valid while mem_ce_i=1. The requester holds a load
  // while stallreq_o=1; the load is answered in the following RESP cycle, where
  // the still-presented load is treated as the held request and not re-issued.
  // Stores never stall and commit at the end of their request cycle.

  logic [0:0]            state_d;
  logic [0:0]            state_q;
  logic                  oor;
  logic                  req_load;
  logic                  req_store;
  logic                  load_issue;
  logic [NUM_LANES-1:0]  we_lane;
  logic [DEPTH_LOG2-1:0] word_idx;
  reg_bus_t              rdata;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^mem_addr_i[1:0];

  assign word_idx  = mem_addr_i[DEPTH_LOG2+1:2];
  assign oor       = |mem_addr_i[31:DEPTH_LOG2+2];
  assign req_load  = (mem_ce_i == CHIP_ENABLE) && (mem_we_i != WRITE_ENABLE);
  assign req_store = (mem_ce_i == CHIP_ENABLE) && (mem_we_i == WRITE_ENABLE);

  always_comb begin
    load_issue = 1'b0;
    we_lane    = '0;
    state_d    = state_q;
    if (req_store && !oor) begin
      we_lane = mem_sel_i;
    end
    case (state_q)
      ST_IDLE: begin
        if (req_load && !oor && !flush_i) begin
          load_issue = 1'b1;
          state_d    = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  data_ram_bank #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .we_lane_i (we_lane),
    .addr_i    (word_idx),
    .wdata_i   (mem_data_i),
    .re_i      (load_issue),
    .rdata_o   (rdata)
  );

  assign stallreq_o  = load_issue;
  assign addr_err_o  = (mem_ce_i == CHIP_ENABLE) && oor;
  assign mem_data_o  = (state_q == ST_RESP) ? rdata : ZERO_WORD;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed scoreboard bench for data_ram_ctrl: per-cycle control expectations
// and load-data expectations are queued by the driver and checked by a monitor.
module tb_data_ram_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic        flush_i;
  logic [31:0] mem_data_o;
  logic        stallreq_o;
  logic        addr_err_o;
  logic [0:0]  dbg_state_o;

  typedef struct packed {
    logic state;
    logic stall;
    logic err;
  } ctl_t;

  logic [31:0] exp_q[$];
  ctl_t        ctl_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          done     = 1'b0;

  data_ram_ctrl #(.DEPTH_LOG2(12)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_ce_i    (mem_ce_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_sel_i   (mem_sel_i),
    .mem_data_i  (mem_data_i),
    .flush_i     (flush_i),
    .mem_data_o  (mem_data_o),
    .stallreq_o  (stallreq_o),
    .addr_err_o  (addr_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver: apply one cycle of inputs, queue its control expectation
  task automatic cyc(input logic ce, input logic we, input logic [31:0] addr,
                     input logic [3:0] sel, input logic [31:0] data, input logic fl,
                     input logic e_state, input logic e_stall, input logic e_err);
    ctl_t c;
    mem_ce_i   = ce;
    mem_we_i   = we;
    mem_addr_i = addr;
    mem_sel_i  = sel;
    mem_data_i = data;
    flush_i    = fl;
    c.state = e_state;
    c.stall = e_stall;
    c.err   = e_err;
    ctl_q.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic store(input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] data, input logic e_err);
    cyc(1'b1, 1'b1, addr, sel, data, 1'b0, 1'b0, 1'b0, e_err);
  endtask

  // load held for its stall cycle and presented again in the answer cycle
  task automatic load(input logic [31:0] addr, input logic [31:0] exp_data);
    exp_q.push_back(exp_data);
    cyc(1'b1, 1'b0, addr, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, addr, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    ctl_t c;
    logic [31:0] e;
    while (!done) begin
      @(negedge clk);
      if (ctl_q.size() > 0) begin
        c = ctl_q.pop_front();
        check("state", {31'h0, dbg_state_o}, {31'h0, c.state});
        check("stallreq", {31'h0, stallreq_o}, {31'h0, c.stall});
        check("addr_err", {31'h0, addr_err_o}, {31'h0, c.err});
      end
      if (dbg_state_o == 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("load_data", mem_data_o, e);
        end
      end else begin
        check("data_idle_zero", mem_data_o, 32'h0);
      end
    end
  end

  initial begin
    rst        = 1'b0;
    mem_ce_i   = 1'b0;
    mem_we_i   = 1'b0;
    mem_addr_i = 32'h0;
    mem_sel_i  = 4'h0;
    mem_data_i = 32'h0;
    flush_i    = 1'b0;
    @(posedge clk);
    #1;
    idle();
    idle();
    rst = 1'b1;
    idle();

    // preload
    store(32'h0000_0000, 4'hF, 32'h1111_1111, 1'b0);
    store(32'h0000_0004, 4'hF, 32'h2222_2222, 1'b0);
    store(32'h0000_0040, 4'hF, 32'h0000_0000, 1'b0);

    // full-word store then immediate load (read-after-write)
    store(32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b0);
    load(32'h0000_0100, 32'hDEAD_BEEF);
    idle();

    // byte lanes
    store(32'h0000_0040, 4'b0100, 32'hAAAA_AAAA, 1'b0);
    store(32'h0000_0040, 4'b0011, 32'h1234_1234, 1'b0);
    load(32'h0000_0040, 32'h00AA_1234);

    // back-to-back loads
    load(32'h0000_0000, 32'h1111_1111);
    load(32'h0000_0004, 32'h2222_2222);
    idle();

    // out of range store and load
    store(32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 1'b1);
    load(32'h0000_0000, 32'h1111_1111);
    cyc(1'b1, 1'b0, 32'h0001_0000, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // last in-range word and first out-of-range word
    store(32'h0000_3FFC, 4'hF, 32'h5A5A_5A5A, 1'b0);
    load(32'h0000_3FFC, 32'h5A5A_5A5A);
    store(32'h0000_4000, 4'hF, 32'h0BAD_0BAD, 1'b1);
    load(32'h0000_0000, 32'h1111_1111);

    // flush suppresses a load in IDLE; empty sel store writes nothing
    cyc(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    store(32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 1'b0);
    load(32'h0000_0004, 32'h2222_2222);

    // flush during RESP still returns to IDLE
    exp_q.push_back(32'hDEAD_BEEF);
    cyc(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();

    // reset asserted while the load would be answered
    cyc(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    idle();
    load(32'h0000_0100, 32'hDEAD_BEEF);
    idle();
    idle();

    done = 1'b1;
    @(posedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("ctl_q_drained", ctl_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
